// File: rtl/bfs_line_cache.sv
// bfs_line_cache
//   Behavioural line cache for the BFS engine. Line read requests are queued,
//   then each line is streamed back one word per cycle with first/last strobes.
//   When MARK_EN is set, bit 0 of the first word of every line read is
//   test-and-set as a "visited" flag; the pre-mark value is returned together
//   with dc_mark_hit. A word write port loads graph data at any time.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   bfs_dc_req     one-cycle line read request
//   bfs_dc_addr    byte address of the requested line
//   dc_ready       request queue can accept a request this cycle
//   dc_rbuf_empty  queue empty, engine idle, no beat on the output
//   dc_valid       dc_rdata holds a line beat
//   dc_fs / dc_ls  first / last beat of a line
//   dc_mark_hit    first beat only: visited bit was already set before the read
//   dc_rdata       beat data
//   dc_ovf         sticky, set when a request is dropped; cleared by reset only
//   wr_en/wr_addr/wr_data  single-cycle word write into storage

module bfs_line_cache #(
  parameter int DATA_W     = 64,
  parameter int LINE_WORDS = 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 32,
  parameter int QDEPTH     = 4,
  parameter int MARK_EN    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bfs_dc_req,
  input  logic [ADDR_W-1:0]        bfs_dc_addr,
  output logic                     dc_ready,
  output logic                     dc_rbuf_empty,
  output logic                     dc_valid,
  output logic                     dc_fs,
  output logic                     dc_ls,
  output logic                     dc_mark_hit,
  output logic [DATA_W-1:0]        dc_rdata,
  output logic                     dc_ovf,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int LW_W    = $clog2(LINE_WORDS);
  localparam int QCNT_W  = $clog2(QDEPTH + 1);
  localparam int QPTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic MARK_ON = (MARK_EN != 0);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Word storage (not reset) and the request queue of line base indices
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  q_mem [QDEPTH];
  logic [QPTR_W-1:0] q_rd;
  logic [QPTR_W-1:0] q_wr;
  logic [QCNT_W-1:0] q_cnt;

  state_t            state;
  logic [IDX_W-1:0]  base;
  logic [LW_W-1:0]   beat;

  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  req_base;
  logic              push;
  logic              pop;
  logic              start_line;
  logic              issue;
  logic              issue_first;
  logic              issue_last;
  logic [LW_W-1:0]   issue_beat;
  logic [IDX_W-1:0]  issue_base;
  logic [IDX_W-1:0]  issue_addr;
  logic              mark_do;
  logic              unused_addr_bits;

  function automatic logic [QPTR_W-1:0] ptr_inc(input logic [QPTR_W-1:0] p);
    return (p == QPTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Only the word-index bits of the byte address matter; the rest are folded
  // here so that they are visibly consumed.
  assign unused_addr_bits = ^bfs_dc_addr;

  // Byte address -> word index (wraps modulo DEPTH) -> line base
  assign req_idx  = IDX_W'(bfs_dc_addr >> BYTE_SH);
  assign req_base = req_idx & ~IDX_W'(LINE_WORDS - 1);

  // Readiness looks only at the registered count, so a pop in the same cycle
  // never makes room for a new request.
  assign dc_ready = (q_cnt < QCNT_W'(QDEPTH));
  assign push     = bfs_dc_req && dc_ready;

  // A new line starts whenever the engine has no line in progress and the
  // queue holds an entry. Beat 0 is read in that same cycle, which gives the
  // two-cycle request-to-data latency and removes any bubble between lines:
  // the engine drops back to IDLE right after issuing the last beat, so the
  // next line's beat 0 follows immediately.
  assign start_line  = (state == IDLE) && (q_cnt != '0);
  assign pop         = start_line;
  assign issue       = start_line || (state == STREAM);
  assign issue_beat  = start_line ? '0 : beat;
  assign issue_base  = start_line ? q_mem[q_rd] : base;
  assign issue_addr  = issue_base + IDX_W'(issue_beat);
  assign issue_first = issue && (issue_beat == '0);
  assign issue_last  = issue && (issue_beat == LW_W'(LINE_WORDS - 1));

  // The visited mark is tied to the beat-0 read and must not fire on a reset
  // edge, since reset aborts the stream.
  assign mark_do = MARK_ON && rst_n && issue_first;

  assign dc_rbuf_empty = (q_cnt == '0) && (state == IDLE) && !dc_valid;

  // Storage: the mark is applied first, so a same-word write in the same
  // cycle overrides it. The registered read elsewhere sees the old contents.
  always_ff @(posedge clk) begin
    if (mark_do) begin
      mem[issue_addr][0] <= 1'b1;
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Queue payload: only written on an accepted request
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[q_wr] <= req_base;
    end
  end

  // Queue pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_rd   <= '0;
      q_wr   <= '0;
      q_cnt  <= '0;
      dc_ovf <= 1'b0;
    end else begin
      if (push) begin
        q_wr <= ptr_inc(q_wr);
      end
      if (pop) begin
        q_rd <= ptr_inc(q_rd);
      end
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
      if (bfs_dc_req && !dc_ready) begin
        dc_ovf <= 1'b1;
      end
    end
  end

  // Streaming engine with registered beat outputs. `beat` holds the index of
  // the next word to read while in STREAM; beat 0 is always read on the
  // IDLE->STREAM transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      beat        <= '0;
      dc_valid    <= 1'b0;
      dc_fs       <= 1'b0;
      dc_ls       <= 1'b0;
      dc_mark_hit <= 1'b0;
      dc_rdata    <= '0;
    end else begin
      dc_valid    <= issue;
      dc_fs       <= issue_first;
      dc_ls       <= issue_last;
      dc_mark_hit <= MARK_ON && issue_first && mem[issue_addr][0];
      if (issue) begin
        dc_rdata <= mem[issue_addr];
      end

      case (state)
        IDLE: begin
          if (start_line) begin
            base  <= q_mem[q_rd];
            beat  <= LW_W'(1);
            state <= STREAM;
          end
        end
        STREAM: begin
          if (beat == LW_W'(LINE_WORDS - 1)) begin
            beat  <= '0;
            state <= IDLE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bfs_line_cache.sv
// tb_bfs_line_cache
//   Drives two instances of bfs_line_cache (visited marking on and off) with
//   the same directed and randomized stimulus and compares every cycle
//   against a reference model built on line start times and a word array.

module tb_bfs_line_cache;

  localparam int DW  = 64;
  localparam int LW  = 8;
  localparam int DEP = 64;
  localparam int AW  = 32;
  localparam int QD  = 4;

  typedef struct {
    int base;
    int start;
  } line_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [AW-1:0] addr;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [DW-1:0] wr_data;

  logic          a_ready, a_empty, a_valid, a_fs, a_ls, a_hit, a_ovf;
  logic [DW-1:0] a_rdata;
  logic          b_ready, b_empty, b_valid, b_fs, b_ls, b_hit, b_ovf;
  logic [DW-1:0] b_rdata;

  // Reference model state
  line_t         mq[$];
  int            cyc;
  int            last_end;
  int            cur_base;
  int            cur_start;
  bit            m_ovf;
  logic [DW-1:0] mem_m [DEP];
  logic [DW-1:0] mem_n [DEP];
  bit            ev, efs, els, ehit_m;
  logic [DW-1:0] edat_m, edat_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bfs_line_cache #(
    .DATA_W(DW), .LINE_WORDS(LW), .DEPTH(DEP), .ADDR_W(AW), .QDEPTH(QD), .MARK_EN(1)
  ) dut_mark (
    .clk(clk), .rst_n(rst_n), .bfs_dc_req(req), .bfs_dc_addr(addr),
    .dc_ready(a_ready), .dc_rbuf_empty(a_empty), .dc_valid(a_valid),
    .dc_fs(a_fs), .dc_ls(a_ls), .dc_mark_hit(a_hit), .dc_rdata(a_rdata),
    .dc_ovf(a_ovf), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  bfs_line_cache #(
    .DATA_W(DW), .LINE_WORDS(LW), .DEPTH(DEP), .ADDR_W(AW), .QDEPTH(QD), .MARK_EN(0)
  ) dut_nomark (
    .clk(clk), .rst_n(rst_n), .bfs_dc_req(req), .bfs_dc_addr(addr),
    .dc_ready(b_ready), .dc_rbuf_empty(b_empty), .dc_valid(b_valid),
    .dc_fs(b_fs), .dc_ls(b_ls), .dc_mark_hit(b_hit), .dc_rdata(b_rdata),
    .dc_ovf(b_ovf), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare both instances against the current-cycle expectations
  task automatic check_output();
    chk("valid", a_valid, ev);
    chk("fs", a_fs, efs);
    chk("ls", a_ls, els);
    chk("mark_hit", a_hit, ehit_m);
    if (ev) chk("rdata", a_rdata, edat_m);
    chk("ready", a_ready, mq.size() < QD);
    chk("rbuf_empty", a_empty, last_end < cyc);
    chk("ovf", a_ovf, m_ovf);
    chk("nomark_valid", b_valid, ev);
    chk("nomark_fs", b_fs, efs);
    chk("nomark_ls", b_ls, els);
    chk("nomark_hit", b_hit, 1'b0);
    if (ev) chk("nomark_rdata", b_rdata, edat_n);
    chk("nomark_ready", b_ready, mq.size() < QD);
    chk("nomark_rbuf_empty", b_empty, last_end < cyc);
    chk("nomark_ovf", b_ovf, m_ovf);
  endtask

  // Advance the model across the clock edge that ends cycle `cyc`.
  // Each accepted line is given a start cycle (its beat 0); it leaves the
  // queue at the edge just before that cycle and owns cycles start..start+LW-1.
  task automatic model_edge();
    bit    rdy;
    int    k;
    int    w;
    int    s;
    line_t e;
    if (!rst_n) begin
      mq.delete();
      m_ovf     = 0;
      last_end  = cyc;
      cur_start = -1000;
      ev = 0; efs = 0; els = 0; ehit_m = 0;
      edat_m = '0; edat_n = '0;
      return;
    end
    rdy = (mq.size() < QD);
    if (mq.size() > 0 && mq[0].start - 1 == cyc) begin
      cur_base  = mq[0].base;
      cur_start = mq[0].start;
      void'(mq.pop_front());
    end
    k = cyc + 1 - cur_start;
    if (k >= 0 && k < LW) begin
      w      = cur_base + k;
      ev     = 1;
      efs    = (k == 0);
      els    = (k == LW - 1);
      edat_m = mem_m[w];
      edat_n = mem_n[w];
      ehit_m = (k == 0) && mem_m[w][0];
      if (k == 0) mem_m[w][0] = 1'b1;
    end else begin
      ev = 0; efs = 0; els = 0; ehit_m = 0;
    end
    if (wr_en) begin
      mem_m[wr_addr] = wr_data;
      mem_n[wr_addr] = wr_data;
    end
    if (req) begin
      if (rdy) begin
        s = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
        e.base  = ((int'(addr) >>> 3) & (DEP - 1)) & ~(LW - 1);
        e.start = s;
        mq.push_back(e);
        last_end = s + LW - 1;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, step the model
  task automatic apply_stimulus(input bit r, input logic [AW-1:0] a, input bit w,
                                input logic [5:0] wa, input logic [DW-1:0] wd, input bit rst);
    req = r; addr = a; wr_en = w; wr_addr = wa; wr_data = wd; rst_n = ~rst;
    @(negedge clk);
    check_output();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    logic [DW-1:0] wd;
    rst_n = 1'b0; req = 1'b0; addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0; last_end = -1; cur_base = 0; cur_start = -1000; m_ovf = 0;
    ev = 0; efs = 0; els = 0; ehit_m = 0; edat_m = '0; edat_n = '0;
    chk("reset_rdata", a_rdata, '0);
    chk("reset_ready", a_ready, 1'b1);
    chk("reset_empty", a_empty, 1'b1);

    // Load storage: words 0..7 hold i<<32, the rest random
    for (int i = 0; i < DEP; i++) begin
      wd = (i < LW) ? (64'(i) << 32) : {$urandom(), $urandom()};
      apply_stimulus(0, '0, 1, 6'(i), wd, 0);
    end

    $display("[TB] single line read of address 0");
    apply_stimulus(1, 32'h0, 0, '0, '0, 0);
    idle(12);

    $display("[TB] repeat read of address 0 (visited bit already set)");
    apply_stimulus(1, 32'h0, 0, '0, '0, 0);
    idle(12);

    $display("[TB] four back-to-back requests");
    for (int i = 0; i < 4; i++) apply_stimulus(1, 32'(i * 64), 0, '0, '0, 0);
    idle(40);

    $display("[TB] overflow: request held for 6 cycles");
    for (int i = 0; i < 6; i++) apply_stimulus(1, $urandom(), 0, '0, '0, 0);
    idle(45);

    $display("[TB] address wrap and write/mark collision");
    apply_stimulus(1, 32'(DEP * 8), 0, '0, '0, 0);
    idle(12);
    apply_stimulus(1, 32'h40, 0, '0, '0, 0);
    apply_stimulus(0, '0, 1, 6'd8, 64'hDEAD_BEEF_0000_1234, 0);
    idle(12);
    apply_stimulus(1, 32'h40, 0, '0, '0, 0);
    idle(12);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom() % 3) == 0, $urandom(), ($urandom() % 4) == 0,
                     6'($urandom()), {$urandom(), $urandom()}, 0);
    end
    idle(50);

    $display("[TB] reset in the middle of a stream");
    apply_stimulus(1, 32'h80, 0, '0, '0, 0);
    apply_stimulus(1, 32'hC0, 0, '0, '0, 0);
    apply_stimulus(1, 32'h100, 0, '0, '0, 0);
    idle(2);
    apply_stimulus(0, '0, 0, '0, '0, 1);
    chk("midrst_valid", a_valid, 1'b0);
    chk("midrst_empty", a_empty, 1'b1);
    chk("midrst_ovf", a_ovf, 1'b0);
    chk("midrst_rdata", a_rdata, '0);
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
